cdm_div32_16: RTL and testbench

Sequential exact 32-by-16 restoring divider: the inverse operation of the carry-disregard multipliers. It accepts a 32-bit product-domain value and a 16-bit divisor and returns a 16-bit quotient and a 16-bit remainder. It recovers an operand from a multiplier result, so error-characterisation logic can compare the approximate 16x16 multipliers against exact results. One quotient bit per cycle, valid/ready on both sides.

---
 rtl/cdm_div32_16.sv | 130 +++++++++++++
 tb/tb_cdm_div32_16.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cdm_div32_16.sv
// cdm_div32_16 -- sequential exact 2N-by-N restoring divider (N=16).
// Recovers an operand from a carry-disregard multiplier result so that
// error-characterisation logic can compare approximate products with exact
// ones. Produces one quotient bit per cycle. Has valid/ready handshakes on
// both the input and the output side.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   dividend [2N-1:0]   value to divide
//   divisor  [N-1:0]    divisor
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   quotient [N-1:0]    quotient ({N{1}} when flagged)
//   remainder[N-1:0]    remainder
//   div_zero            divisor was zero
//   overflow            quotient would not fit in N bits
module cdm_div32_16 #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero,
    output logic           overflow
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    div_r;
    logic [N:0]      prem;      // partial remainder
    logic [N-1:0]    sreg;      // dividend low half shifts out, quotient bits shift in
    logic [CW-1:0]   cnt;

    logic            is_zero, is_ovf, accept, last;
    logic [N+1:0]    sh, diff;
    logic            qbit;
    logic [N:0]      prem_nxt;
    logic [N-1:0]    sreg_nxt;

    assign is_zero = (divisor == '0);
    assign is_ovf  = !is_zero && (dividend[2*N-1:N] >= divisor);
    assign accept  = (state == IDLE) && in_valid;
    assign last    = (cnt == CW'(N - 1));

    // The partial remainder always stays below the divisor, so the shifted
    // value is below 2*divisor. The trial difference fits in N+2 bits, and
    // its top bit is the sign.
    always_comb begin
        sh       = {prem, sreg[N-1]};
        diff     = sh - {2'b00, div_r};
        qbit     = ~diff[N+1];
        prem_nxt = qbit ? diff[N:0] : sh[N:0];
        sreg_nxt = {sreg[N-2:0], qbit};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (is_zero || is_ovf) ? DONE : CALC;
            CALC: if (last)     state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath. The result registers only change when a new result loads.
    // This keeps them stable through backpressure and after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r     <= '0;
            prem      <= '0;
            sreg      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            div_r <= divisor;
            if (is_zero) begin
                quotient  <= '1;
                remainder <= dividend[N-1:0];
                div_zero  <= 1'b1;
                overflow  <= 1'b0;
            end else if (is_ovf) begin
                quotient  <= '1;
                remainder <= '0;
                div_zero  <= 1'b0;
                overflow  <= 1'b1;
            end else begin
                prem <= {1'b0, dividend[2*N-1:N]};
                sreg <= dividend[N-1:0];
                cnt  <= '0;
            end
        end else if (state == CALC) begin
            prem <= prem_nxt;
            sreg <= sreg_nxt;
            cnt  <= cnt + 1'b1;
            if (last) begin
                quotient  <= sreg_nxt;
                remainder <= prem_nxt[N-1:0];
                div_zero  <= 1'b0;
                overflow  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdm_div32_16.sv
module tb_cdm_div32_16;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cdm_div32_16 dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_zero(div_zero), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for in_ready, then present one operand pair for one
    // accept edge. The task returns #1 after that edge.
    task automatic issue(input logic [31:0] dvd, input logic [15:0] dvs);
        int w = 0;
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Return the number of clock edges after the accept edge up to the first
    // edge that samples out_valid high.
    task automatic wait_valid(output int lat);
        int w = 0;
        while (!out_valid && w < 60) begin
            @(posedge clk); #1; w++;
        end
        lat = w + 1;
    endtask

    task automatic run_div(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                           input logic [15:0] eq, input logic [15:0] er,
                           input logic ez, input logic eo, input int elat);
        int lat;
        issue(dvd, dvs);
        wait_valid(lat);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
        chk({tag, "_r"}, {16'd0, remainder}, {16'd0, er});
        chk({tag, "_flags"}, {30'd0, div_zero, overflow}, {30'd0, ez, eo});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ovalid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_iready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int t_prev;
        int t_acc;
        logic [15:0] a, b;
        logic [15:0] hq, hr;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient",  {16'd0, quotient},  32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_flags",     {30'd0, div_zero, overflow}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        run_div("basic",  32'h12345678, 16'hABCD, 16'h1B20, 16'h3DD8, 1'b0, 1'b0, 17);
        run_div("maxprod",32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17);
        run_div("million",32'h000F4240, 16'h03E8, 16'h03E8, 16'h0000, 1'b0, 1'b0, 17);
        run_div("divzero",32'h12345678, 16'h0000, 16'hFFFF, 16'h5678, 1'b1, 1'b0, 1);
        run_div("ovf",    32'h00010000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1);

        // Backpressure: the result holds while out_ready is low, and a new
        // request during DONE is ignored.
        issue(32'h000F4240, 16'h03E8);
        wait_valid(lat);
        chk("bp_lat", lat, 17);
        hq = quotient; hr = remainder;
        dividend = 32'h00000064; divisor = 16'h0007; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready",   {31'd0, in_ready},  32'd0);
            chk("bp_hold_q",     {16'd0, quotient},  32'h03E8);
            chk("bp_hold_r",     {16'd0, remainder}, 32'h0000);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready},  32'd1);
        chk("bp_sticky_q", {16'd0, quotient}, {16'd0, hq});
        chk("bp_sticky_r", {16'd0, remainder}, {16'd0, hr});

        // Asynchronous reset in the middle of CALC
        issue(32'h12345678, 16'hABCD);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_quotient",  {16'd0, quotient},  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_result", {31'd0, out_valid}, 32'd0);
        run_div("after_rst", 32'h00000064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 17);

        // Back-to-back exact products with out_ready held high
        out_ready = 1'b1;
        t_prev = -1;
        for (int k = 0; k < 4; k++) begin
            a = 16'($urandom_range(1, 65535));
            b = 16'($urandom_range(1, 65535));
            dividend = 32'(a) * 32'(b);
            divisor  = b;
            in_valid = 1'b1;
            for (int w = 0; w < 50 && !in_ready; w++) begin
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            t_acc = cyc;
            in_valid = 1'b0;
            if (t_prev >= 0) chk("b2b_period", t_acc - t_prev, 18);
            t_prev = t_acc;
            wait_valid(lat);
            chk("b2b_lat", lat, 17);
            chk("b2b_q", {16'd0, quotient},  {16'd0, a});
            chk("b2b_r", {16'd0, remainder}, 32'd0);
            chk("b2b_flags", {30'd0, div_zero, overflow}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("final_idle", {31'd0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
